// File: rtl/jelly2_ram_autoclear_range.sv
// Single-clock RAM with a background range-clear engine that fills an address window with a fill value.
// Optional: JELLY2_RAM_AUTOCLEAR_READ_BYPASS_EN lets reads of pending words through, returning the fill value.

module jelly2_ram_autoclear_range #(
   parameter int ADDR_WIDTH = 12,
   parameter int WE_WIDTH   = 1,
   parameter int WORD_WIDTH = 8,
   parameter int DATA_WIDTH = WE_WIDTH * WORD_WIDTH,
   parameter int MEM_SIZE   = 1 << ADDR_WIDTH,
   parameter     RAM_TYPE   = "block",
   parameter int DOUT_REGS  = 0
) (
   input  logic                  reset,
   input  logic                  clk,

   input  logic                  clear_start,
   input  logic [ADDR_WIDTH-1:0] clear_first,
   input  logic [ADDR_WIDTH-1:0] clear_last,
   input  logic [DATA_WIDTH-1:0] clear_din,
   input  logic                  clear_abort,
   output logic                  clear_busy,
   output logic                  clear_done,

   input  logic                  s_en,
   input  logic [WE_WIDTH-1:0]   s_we,
   input  logic [ADDR_WIDTH-1:0] s_addr,
   input  logic [DATA_WIDTH-1:0] s_din,
   output logic                  s_ready,

   input  logic                  regcke,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid
);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
   logic [ADDR_WIDTH-1:0] last_q, last_d;
   logic [DATA_WIDTH-1:0] fill_q, fill_d;
   logic                  done_q, done_d;

   logic s_in_range, clr_in_range, pending, s_write;
   logic acc, rd_a, wr_a, wr_b;

   assign s_in_range   = ({1'b0, s_addr} < MEM_LIMIT);
   assign clr_in_range = ({1'b0, cursor_q} < MEM_LIMIT);
   assign pending      = (state_q == ST_CLEAR) && (s_addr >= cursor_q) && (s_addr <= last_q);
   assign s_write      = |s_we;

`ifdef JELLY2_RAM_AUTOCLEAR_READ_BYPASS_EN
   assign s_ready = !(pending && s_write);
`else
   assign s_ready = !pending;
`endif

   assign acc  = s_en && s_ready;
   assign wr_a = acc && s_write && s_in_range;
   assign rd_a = acc && !s_write && s_in_range;
   // The cursor word is always pending, so user and clear writes never collide.
   assign wr_b = (state_q == ST_CLEAR) && clr_in_range;

   assign clear_busy = (state_q == ST_CLEAR);
   assign clear_done = done_q;

   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      last_d   = last_q;
      fill_d   = fill_q;
      done_d   = 1'b0;
      if (state_q == ST_CLEAR) begin
         cursor_d = cursor_q + 1'b1;
         if (cursor_q == last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end
      if (clear_abort) begin
         if (state_q == ST_CLEAR) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
         end
      end else if (clear_start) begin
         if (clear_first <= clear_last) begin
            state_d  = ST_CLEAR;
            cursor_d = clear_first;
            last_d   = clear_last;
            fill_d   = clear_din;
            done_d   = 1'b0;
         end else begin
            // Empty range completes immediately.
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cursor_q <= '0;
         last_q   <= '0;
         fill_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cursor_q <= cursor_d;
         last_q   <= last_d;
         fill_q   <= fill_d;
         done_q   <= done_d;
      end
   end

   (* ram_style = RAM_TYPE *)
   logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];

   always_ff @(posedge clk) begin
      if (wr_a) begin
         for (int i = 0; i < WE_WIDTH; i++) begin
            if (s_we[i]) mem[s_addr][i*WORD_WIDTH +: WORD_WIDTH] <= s_din[i*WORD_WIDTH +: WORD_WIDTH];
         end
      end
      if (wr_b) mem[cursor_q] <= fill_q;
   end

   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_vld_q, rd_vld_d;

   assign rd_vld_d = rd_a;

   // Read-first: a same-cycle user write is seen by the next read only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
      end else begin
         rd_vld_q <= rd_vld_d;
         if (rd_a) rd_data_q <= mem[s_addr];
      end
   end

   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_vld;

`ifdef JELLY2_RAM_AUTOCLEAR_READ_BYPASS_EN
   logic rd_byp_q, rd_byp_d, out_byp;

   assign rd_byp_d = pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     rd_byp_q <= 1'b0;
      else if (rd_a) rd_byp_q <= rd_byp_d;
   end
`endif

   generate
      if (DOUT_REGS != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] data2_q;
         logic                  vld2_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               data2_q <= '0;
               vld2_q  <= 1'b0;
            end else if (regcke) begin
               data2_q <= rd_data_q;
               vld2_q  <= rd_vld_q;
            end
         end
         assign out_data = data2_q;
         assign out_vld  = vld2_q;
`ifdef JELLY2_RAM_AUTOCLEAR_READ_BYPASS_EN
         logic byp2_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset)       byp2_q <= 1'b0;
            else if (regcke) byp2_q <= rd_byp_q;
         end
         assign out_byp = byp2_q;
`endif
      end else begin : g_noreg
         logic unused_regcke;
         assign unused_regcke = regcke;
         assign out_data = rd_data_q;
         assign out_vld  = rd_vld_q;
`ifdef JELLY2_RAM_AUTOCLEAR_READ_BYPASS_EN
         assign out_byp  = rd_byp_q;
`endif
      end
   endgenerate

`ifdef JELLY2_RAM_AUTOCLEAR_READ_BYPASS_EN
   assign dout = out_byp ? fill_q : out_data;
`else
   assign dout = out_data;
`endif
   assign dout_valid = out_vld;

endmodule
